i2s_dac_tx: RTL and testbench
=============================

// Module: i2s_dac_tx
// PURPOSE
//  I2S transmitter for the anti-noise path. Takes the signed 16-bit anti-noise
//  sample produced by the FIR stage (y_out, strobed once per sample) and
//  serialises it to the speaker DAC as standard Philips I2S. Sends the same
//  sample on the left and right slots. Generates BCLK/LRCLK itself from clk_in.
//  Output end of the ANC pipeline, the counterpart of the mic-side receive path.
// PARAMETERS
//  BCLK_DIV  4   clk_in cycles per BCLK period; must be even and >= 2
//  WIDTH     16  sample width; sent MSB-first in a 32-bit slot, zero padded
// PORTS
//  clk_in           in   1      system clock
//  rst_in           in   1      synchronous, active-high reset
//  ready_in         in   1      1-cycle strobe: sample_in valid this cycle
//  sample_in        in   WIDTH  signed two's-complement anti-noise sample
//  bclk_out         out  1      I2S bit clock, 50% duty
//  lrclk_out        out  1      I2S word select: 0=left, 1=right
//  sdata_out        out  1      I2S serial data; changes only on BCLK falling edge
//  frame_start_out  out  1      1-cycle pulse when a new frame (slot b=0) begins
//  overrun_out      out  1      1-cycle pulse when an unsent pending sample is overwritten
// BEHAVIOUR
//  Reset: div_cnt=0, bit_cnt=0, pending=0, pend_valid=0, frame_reg=0.
//   Outputs: bclk_out=0, lrclk_out=0, sdata_out=0, frame_start_out=0, overrun_out=0.
//   Reset mid-frame aborts the frame at once; the pending sample is discarded.
//  Divider: div_cnt counts 0..BCLK_DIV-1 and wraps.
//   bclk_out (registered) = 0 while div_cnt < BCLK_DIV/2, otherwise 1.
//   Fall event = the cycle div_cnt wraps BCLK_DIV-1 -> 0.
//  Frame: bit_cnt b in 0..63 advances by 1 (mod 64) on each fall event.
//   Frame length = 64*BCLK_DIV clk cycles. Default: 256 cycles, BCLK = clk/4.
//  Slots: p = b mod 32. Left slot when b<32, right slot when b>=32.
//   sdata_out = frame_reg[WIDTH-1-p] when p<WIDTH, else 0.
//  LRCLK: lrclk_out = 1 for b in 31..62, else 0.
//   This gives the I2S one-BCLK lead: WS changes one BCLK before the MSB.
//  lrclk_out and sdata_out update only in fall-event cycles.
//  Input capture: on ready_in, pending <= sample_in and pend_valid <= 1.
//   If pend_valid was already 1 and the same cycle is not a frame load,
//   pulse overrun_out. The newest sample wins.
//  Frame load: the fall event that takes b 63->0 is the frame load.
//   In that cycle: frame_reg <= pend_valid ? pending : frame_reg, pend_valid <= 0,
//   frame_start_out pulses.
//   sdata_out for b=0 uses the newly loaded value (MSB appears in this cycle).
//   No new sample -> the previous sample repeats (hold; no zero insertion).
//  ready_in in the frame-load cycle: the load takes the old pending.
//   The new sample goes to pending with pend_valid=1. No overrun pulse.
//  Latency: a sample accepted at cycle t reaches sdata MSB at the next frame
//   load, at most 64*BCLK_DIV cycles later.
//  The sample is the same for both slots (mono). Sign is carried by the MSB.
//   No rounding or saturation; bits go out verbatim.
// TESTING (BCLK_DIV=4, frame = 256 cycles)
//  1 Reset, then idle 300 cycles -> bclk period 4 with 2 low/2 high;
//    lrclk high for BCLK periods 31..62; sdata always 0;
//    frame_start pulses every 256 cycles.
//  2 Strobe 16'h8001 once -> next frame, left and right slots each carry
//    1,0x14,1 then 16 zeros. Following frames repeat 16'h8001.
//  3 Strobe 16'h1234, then 16'hFFFF, both before the next load ->
//    overrun_out pulses once on the second strobe; frame carries 16'hFFFF.
//  4 Strobe 16'h00F0 exactly in the frame-load cycle -> current frame sends the
//    old pending value, next frame sends 16'h00F0, no overrun pulse.
//  5 Assert rst_in at b=40 with 16'hAAAA loaded and 16'h5555 pending ->
//    next cycle all outputs are 0. After release, 16'h5555 is never sent.
//  6 Random strobes, one per 256..512 cycles, against an I2S receiver model ->
//    every decoded left==right equals the latest accepted sample; no overrun.

Source files
------------

// File: rtl/i2s_dac_tx.sv
// i2s_dac_tx: Philips I2S transmitter for the anti-noise output path.
// Generates BCLK/LRCLK from the system clock and sends each accepted
// 16-bit sample MSB-first in both the left and right 32-bit slots.
// A new sample is latched into the frame register only at the frame
// boundary. If no new sample has arrived, the previous one repeats.
module i2s_dac_tx #(
    parameter int BCLK_DIV = 4,
    parameter int WIDTH    = 16
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             ready_in,
    input  logic [WIDTH-1:0] sample_in,
    output logic             bclk_out,
    output logic             lrclk_out,
    output logic             sdata_out,
    output logic             frame_start_out,
    output logic             overrun_out
);

    localparam int DIV_W = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic [5:0]       bit_cnt;
    logic [WIDTH-1:0] pending;
    logic             pend_valid;
    logic [WIDTH-1:0] frame_reg;

    logic             fall_event;
    logic             frame_load;
    logic [DIV_W-1:0] div_next;
    logic [5:0]       bit_next;
    logic [4:0]       slot_pos;
    logic [WIDTH-1:0] frame_next;
    logic [WIDTH-1:0] frame_shifted;
    logic             bclk_next;
    logic             lrclk_next;
    logic             sdata_next;

    // Next-state values for the divider, bit counter and serial outputs.
    // The outputs are registered, so they are computed from the values the
    // counters take after this edge.
    // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        fall_event    = 1'b0;
        frame_load    = 1'b0;
        div_next      = '0;
        bit_next      = bit_cnt + 6'd1;
        slot_pos      = '0;
        frame_next    = frame_reg;
        frame_shifted = '0;
        bclk_next     = 1'b0;
        lrclk_next    = 1'b0;
        sdata_next    = 1'b0;

        fall_event = (div_cnt == DIV_W'(BCLK_DIV - 1));
        div_next   = fall_event ? '0 : div_cnt + 1'b1;
        bclk_next  = (int'(div_next) >= BCLK_DIV / 2);

        // The fall event that wraps b from 63 to 0 starts a new frame.
        frame_load = fall_event && (bit_cnt == 6'd63);
        if (frame_load && pend_valid) begin
            frame_next = pending;
        end

        // The slot position of the bit that goes out after this fall event.
        // Bits past WIDTH are zero padding.
        slot_pos      = bit_next[4:0];
        frame_shifted = frame_next << slot_pos;
        sdata_next    = (int'(slot_pos) < WIDTH) ? frame_shifted[WIDTH-1] : 1'b0;

        // WS leads the MSB by one BCLK. It is high for b = 31..62.
        lrclk_next = (bit_next >= 6'd31) && (bit_next <= 6'd62);
    end

    // Registers for the counters, sample buffers and all outputs.
    // Reset is synchronous and aborts any frame in progress.
    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values, with no ordering races.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            div_cnt         <= '0;
            bit_cnt         <= '0;
            pending         <= '0;
            pend_valid      <= 1'b0;
            frame_reg       <= '0;
            bclk_out        <= 1'b0;
            lrclk_out       <= 1'b0;
            sdata_out       <= 1'b0;
            frame_start_out <= 1'b0;
            overrun_out     <= 1'b0;
        end else begin
            div_cnt         <= div_next;
            bclk_out        <= bclk_next;
            frame_start_out <= frame_load;
            // A strobe that lands on the load cycle refills a buffer that was
            // just emptied, so it is not an overrun.
            overrun_out     <= ready_in && pend_valid && !frame_load;

            if (fall_event) begin
                bit_cnt   <= bit_next;
                lrclk_out <= lrclk_next;
                sdata_out <= sdata_next;
                frame_reg <= frame_next;
            end

            // The newest sample always wins the pending slot.
            if (ready_in) begin
                pending    <= sample_in;
                pend_valid <= 1'b1;
            end else if (frame_load) begin
                pend_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// tb_i2s_dac_tx: directed bench for the I2S DAC transmitter.
// It decodes the serial stream with an I2S receiver model. A small
// sample/frame model supplies the expected values for random traffic.
module tb_i2s_dac_tx;

    localparam int BCLK_DIV = 4;
    localparam int WIDTH    = 16;

    logic             clk_in = 1'b0;
    logic             rst_in;
    logic             ready_in;
    logic [WIDTH-1:0] sample_in;
    logic             bclk_out;
    logic             lrclk_out;
    logic             sdata_out;
    logic             frame_start_out;
    logic             overrun_out;

    int checks = 0;
    int errors = 0;

    i2s_dac_tx #(.BCLK_DIV(BCLK_DIV), .WIDTH(WIDTH)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .ready_in        (ready_in),
        .sample_in       (sample_in),
        .bclk_out        (bclk_out),
        .lrclk_out       (lrclk_out),
        .sdata_out       (sdata_out),
        .frame_start_out (frame_start_out),
        .overrun_out     (overrun_out)
    );

    always #5 clk_in = ~clk_in;

    // Reference model of the sample path. It updates on the rising edge.
    int          m_k     = 0;
    logic        m_pv    = 1'b0;
    logic [15:0] m_pend  = '0;
    logic [15:0] m_frame = '0;
    always @(posedge clk_in) begin
        if (rst_in) begin
            m_k = 0; m_pv = 1'b0; m_pend = '0; m_frame = '0;
        end else begin
            m_k++;
            if (m_k % 256 == 0) begin
                if (m_pv) m_frame = m_pend;
                m_pv = 1'b0;
                if (ready_in) begin m_pend = sample_in; m_pv = 1'b1; end
            end else if (ready_in) begin
                m_pend = sample_in; m_pv = 1'b1;
            end
        end
    end

    // I2S receiver: it shifts on each BCLK rise. A WS change marks the last bit of a slot.
    logic        prev_bclk   = 1'b0;
    logic        prev_lr     = 1'b0;
    logic [31:0] rx_shift    = '0;
    logic [31:0] rx_left     = '0;
    logic [31:0] last_left   = '0;
    logic [31:0] last_right  = '0;
    logic [15:0] cur_exp     = '0;
    logic [15:0] last_exp    = '0;
    int          frames_done = 0;
    int          overrun_cnt = 0;
    always @(negedge clk_in) begin
        if (rst_in) begin
            prev_bclk = 1'b0; prev_lr = 1'b0; rx_shift = '0; cur_exp = '0;
        end else begin
            if (overrun_out) overrun_cnt++;
            if (frame_start_out) cur_exp = m_frame;
            if (bclk_out && !prev_bclk) begin
                rx_shift = {rx_shift[30:0], sdata_out};
                if (lrclk_out != prev_lr) begin
                    if (!prev_lr) begin
                        rx_left = rx_shift;
                    end else begin
                        last_left  = rx_shift;
                        last_right = rx_shift;
                        last_left  = rx_left;
                        last_exp   = cur_exp;
                        frames_done++;
                    end
                    prev_lr = lrclk_out;
                end
            end
            prev_bclk = bclk_out;
        end
    end

    task automatic step();
        @(negedge clk_in);
        #1;
    endtask

    task automatic strobe(input logic [15:0] val);
        ready_in  = 1'b1;
        sample_in = val;
        step();
        ready_in  = 1'b0;
    endtask

    task automatic wait_fs(input string name);
        int n;
        n = 0;
        while (!frame_start_out && n < 600) begin step(); n++; end
        if (!frame_start_out) begin
            errors++;
            $display("FAIL %s: frame_start timeout, waited %0d cycles, required <600", name, n);
        end
    endtask

    task automatic wait_frames(input int target, input string name);
        int n;
        n = 0;
        while (frames_done < target && n < 1200) begin step(); n++; end
        if (frames_done < target) begin
            errors++;
            $display("FAIL %s: frame decode timeout, got %0d frames, required %0d", name, frames_done, target);
        end
    endtask

    task automatic check_frame(input string name, input logic [15:0] exp);
        checks++;
        if (last_left !== {exp, 16'h0000}) begin
            errors++;
            $display("FAIL %s left: got %h, required %h", name, last_left, {exp, 16'h0000});
        end
        checks++;
        if (last_right !== {exp, 16'h0000}) begin
            errors++;
            $display("FAIL %s right: got %h, required %h", name, last_right, {exp, 16'h0000});
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b1; ready_in = 1'b0; sample_in = '0;
        step(); step();
        checks++;
        if ({bclk_out, lrclk_out, sdata_out, frame_start_out, overrun_out} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, required 00000",
                     {bclk_out, lrclk_out, sdata_out, frame_start_out, overrun_out});
        end
        rst_in = 1'b0;
    endtask

    task automatic test_idle();
        logic [4:0] exp;
        logic [4:0] got;
        int b;
        for (int k = 1; k <= 300; k++) begin
            step();
            b   = (k / 4) % 64;
            exp = {((k % 4) >= 2), (b >= 31 && b <= 62), 1'b0, (k % 256 == 0), 1'b0};
            got = {bclk_out, lrclk_out, sdata_out, frame_start_out, overrun_out};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL idle k=%0d {bclk,lr,sd,fs,ov}: got %b, required %b", k, got, exp);
            end
        end
    endtask

    task automatic test_single();
        int c;
        int o0;
        o0 = overrun_cnt;
        strobe(16'h8001);
        wait_fs("single");
        c = frames_done;
        wait_frames(c + 1, "single");
        check_frame("single_first", 16'h8001);
        wait_frames(c + 2, "single");
        check_frame("single_repeat", 16'h8001);
        checks++;
        if (overrun_cnt !== o0) begin
            errors++;
            $display("FAIL single_overrun: got %0d pulses, required 0", overrun_cnt - o0);
        end
    endtask

    task automatic test_overrun();
        int c;
        int o0;
        wait_fs("overrun");
        for (int i = 0; i < 10; i++) step();
        o0 = overrun_cnt;
        strobe(16'h1234);
        checks++;
        if (overrun_out !== 1'b0) begin
            errors++;
            $display("FAIL overrun_first_strobe: got %b, required 0", overrun_out);
        end
        for (int i = 0; i < 5; i++) step();
        strobe(16'hFFFF);
        checks++;
        if (overrun_out !== 1'b1) begin
            errors++;
            $display("FAIL overrun_pulse: got %b, required 1", overrun_out);
        end
        step();
        checks++;
        if (overrun_cnt !== o0 + 1) begin
            errors++;
            $display("FAIL overrun_count: got %0d pulses, required 1", overrun_cnt - o0);
        end
        wait_fs("overrun");
        c = frames_done;
        wait_frames(c + 1, "overrun");
        check_frame("overrun_newest", 16'hFFFF);
    endtask

    task automatic test_load_strobe();
        int c;
        int o0;
        wait_fs("load_strobe");
        o0 = overrun_cnt;
        strobe(16'h3C3C);
        for (int i = 0; i < 254; i++) step();
        strobe(16'h00F0);
        checks++;
        if (frame_start_out !== 1'b1 || overrun_out !== 1'b0) begin
            errors++;
            $display("FAIL load_strobe_edge {fs,ov}: got %b%b, required 10", frame_start_out, overrun_out);
        end
        c = frames_done;
        wait_frames(c + 1, "load_strobe");
        check_frame("load_strobe_old", 16'h3C3C);
        wait_frames(c + 2, "load_strobe");
        check_frame("load_strobe_new", 16'h00F0);
        checks++;
        if (overrun_cnt !== o0) begin
            errors++;
            $display("FAIL load_strobe_overrun: got %0d pulses, required 0", overrun_cnt - o0);
        end
    endtask

    task automatic test_reset_mid();
        int c;
        wait_fs("reset_mid");
        strobe(16'hAAAA);
        wait_fs("reset_mid");
        strobe(16'h5555);
        for (int i = 0; i < 159; i++) step();
        // b=40 is slot position 8 of the right slot. Bit 7 of 16'hAAAA is 1.
        checks++;
        if (lrclk_out !== 1'b1 || sdata_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_pre {lr,sd}: got %b%b, required 11", lrclk_out, sdata_out);
        end
        rst_in = 1'b1;
        step();
        checks++;
        if ({bclk_out, lrclk_out, sdata_out, frame_start_out, overrun_out} !== 5'b0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got %b, required 00000",
                     {bclk_out, lrclk_out, sdata_out, frame_start_out, overrun_out});
        end
        rst_in = 1'b0;
        c = frames_done;
        wait_frames(c + 1, "reset_mid");
        check_frame("reset_mid_frame1", 16'h0000);
        wait_frames(c + 2, "reset_mid");
        check_frame("reset_mid_frame2", 16'h0000);
    endtask

    task automatic test_random();
        int          o0;
        int          seen;
        int          gap;
        int          c;
        logic [15:0] val;
        o0   = overrun_cnt;
        seen = frames_done;
        val  = '0;
        for (int i = 0; i < 6; i++) begin
            gap = $urandom_range(256, 512);
            for (int j = 0; j < gap; j++) begin
                step();
                if (frames_done != seen) begin
                    seen = frames_done;
                    checks++;
                    if (last_left !== last_right || last_left !== {last_exp, 16'h0000}) begin
                        errors++;
                        $display("FAIL random_frame: got L=%h R=%h, required %h",
                                 last_left, last_right, {last_exp, 16'h0000});
                    end
                end
            end
            val = 16'($urandom);
            strobe(val);
        end
        wait_fs("random");
        c = frames_done;
        wait_frames(c + 1, "random");
        check_frame("random_last", val);
        checks++;
        if (overrun_cnt !== o0) begin
            errors++;
            $display("FAIL random_overrun: got %0d pulses, required 0", overrun_cnt - o0);
        end
    endtask

    initial begin
        rst_in = 1'b1; ready_in = 1'b0; sample_in = '0;
        test_reset();
        test_idle();
        test_single();
        test_overrun();
        test_load_strobe();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
